// File: rtl/mult_datapath.sv
// Datapath for the 8-bit signed add-shift multiplier: sign bit X, accumulator A, multiplier B
// and a 9-bit adder/subtractor, driven by per-cycle strobes from the control FSM.
module mult_datapath (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_a,
    input  logic       load_b,
    input  logic       add_en,
    input  logic       sub_en,
    input  logic       shift_en,
    input  logic [7:0] sw,
    input  logic [7:0] s_in,
    output logic       b_lsb,
    output logic       x_out,
    output logic [7:0] a_out,
    output logic [7:0] b_out
);

    logic       x_q, x_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [8:0] sum;

    // add_en outranks sub_en, so subtract only when add_en is low
    always_comb begin
        if (sub_en && !add_en) begin
            sum = {a_q[7], a_q} + ~{s_in[7], s_in} + 9'd1;
        end else begin
            sum = {a_q[7], a_q} + {s_in[7], s_in};
        end
    end

    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        if (clear_a) begin
            x_d = 1'b0;
            a_d = 8'h00;
            if (load_b) begin
                b_d = sw;
            end
        end else if (load_b) begin
            b_d = sw;
        end else if (add_en || sub_en) begin
            {x_d, a_d} = sum;
        end else if (shift_en) begin
            a_d = {x_q, a_q[7:1]};
            b_d = {a_q[0], b_q[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= 1'b0;
            a_q <= 8'h00;
            b_q <= 8'h00;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign x_out = x_q;
    assign a_out = a_q;
    assign b_out = b_q;
    assign b_lsb = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: stimulus pushes hand-computed expected register values,
// a monitor pops and compares one entry after every clock edge that had stimulus.
module tb_mult_datapath;

    logic       clk = 1'b0;
    logic       reset, clear_a, load_b, add_en, sub_en, shift_en;
    logic [7:0] sw, s_in;
    logic       b_lsb, x_out;
    logic [7:0] a_out, b_out;

    typedef struct packed {
        logic       chk;
        logic       x;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    tests = 0;
    int    fails = 0;

    mult_datapath dut (
        .clk      (clk),
        .reset    (reset),
        .clear_a  (clear_a),
        .load_b   (load_b),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .shift_en (shift_en),
        .sw       (sw),
        .s_in     (s_in),
        .b_lsb    (b_lsb),
        .x_out    (x_out),
        .a_out    (a_out),
        .b_out    (b_out)
    );

    always #5 clk = ~clk;

    // cmd bits: {reset, clear_a, load_b, add_en, sub_en, shift_en}
    task automatic drive(input logic [5:0] cmd, input logic [7:0] swv, input logic [7:0] sv,
                         input logic chk, input logic ex, input logic [7:0] ea,
                         input logic [7:0] eb, input string nm);
        @(negedge clk);
        {reset, clear_a, load_b, add_en, sub_en, shift_en} = cmd;
        sw   = swv;
        s_in = sv;
        sb_q.push_back('{chk: chk, x: ex, a: ea, b: eb});
        nm_q.push_back(nm);
    endtask

    // Control algorithm: add on B[0]=1, sub before the 8th shift, using the known multiplier bits.
    task automatic multiply(input logic [7:0] m, input logic [7:0] s, input int iters,
                            input logic ex, input logic [7:0] ea, input logic [7:0] eb,
                            input string nm);
        drive(6'b011000, m, s, 1'b1, 1'b0, 8'h00, m, {nm, "_load"});
        for (int i = 0; i < iters; i++) begin
            if (m[i]) begin
                if (i == 7) drive(6'b000010, 8'h00, s, 1'b0, 1'b0, 8'h00, 8'h00, nm);
                else        drive(6'b000100, 8'h00, s, 1'b0, 1'b0, 8'h00, 8'h00, nm);
            end
            drive(6'b000001, 8'h00, s, (i == iters - 1), ex, ea, eb, {nm, "_result"});
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n = nm_q.pop_front();
                if (e.chk) begin
                    tests++;
                    if ({x_out, a_out, b_out, b_lsb} !== {e.x, e.a, e.b, e.b[0]}) begin
                        fails++;
                        $display("FAIL %s: got x=%0b a=%h b=%h lsb=%0b, want x=%0b a=%h b=%h lsb=%0b",
                                 n, x_out, a_out, b_out, b_lsb, e.x, e.a, e.b, e.b[0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        {reset, clear_a, load_b, add_en, sub_en, shift_en} = 6'b000000;
        sw   = 8'h00;
        s_in = 8'h00;

        drive(6'b111100, 8'hAA, 8'h7F, 1'b1, 1'b0, 8'h00, 8'h00, "reset");

        drive(6'b011000, 8'hFD, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFD, "clear_load");
        drive(6'b000100, 8'h00, 8'hC5, 1'b1, 1'b1, 8'hC5, 8'hFD, "add_neg");
        drive(6'b000100, 8'h00, 8'h80, 1'b1, 1'b1, 8'h45, 8'hFD, "add_overflow");
        drive(6'b000000, 8'h11, 8'h22, 1'b1, 1'b1, 8'h45, 8'hFD, "hold_idle");

        drive(6'b011000, 8'h03, 8'h00, 1'b1, 1'b0, 8'h00, 8'h03, "load_03");
        drive(6'b000010, 8'h00, 8'h07, 1'b1, 1'b1, 8'hF9, 8'h03, "sub");
        drive(6'b000001, 8'h00, 8'h07, 1'b1, 1'b1, 8'hFC, 8'h81, "shift_sign");

        multiply(8'hFD, 8'h07, 8, 1'b1, 8'hFF, 8'hEB, "mul_7_m3");

        drive(6'b011000, 8'h5A, 8'h00, 1'b1, 1'b0, 8'h00, 8'h5A, "prio_setup");
        drive(6'b000100, 8'h00, 8'h10, 1'b1, 1'b0, 8'h10, 8'h5A, "prio_a10");
        drive(6'b000111, 8'h00, 8'h01, 1'b1, 1'b0, 8'h11, 8'h5A, "prio_add_wins");
        drive(6'b001001, 8'h3C, 8'h01, 1'b1, 1'b0, 8'h11, 8'h3C, "prio_load_over_shift");
        drive(6'b010000, 8'hC3, 8'h01, 1'b1, 1'b0, 8'h00, 8'h3C, "prio_clear_b_holds");
        drive(6'b000011, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 8'h3C, "prio_sub_over_shift");

        multiply(8'h80, 8'h80, 4, 1'b0, 8'h00, 8'h08, "mul_partial");
        drive(6'b100101, 8'h00, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00, "mid_reset");
        multiply(8'h80, 8'h80, 8, 1'b0, 8'h40, 8'h00, "mul_m128_m128");

        drive(6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "idle");
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Register/arithmetic datapath for the 8-bit signed add-shift multiplier. It holds sign-extension bit X, accumulator A and multiplier B, and contains the 9-bit adder/subtractor. It consumes per-cycle command strobes from the multiplier control FSM and returns B[0] to that FSM. The final 16-bit product {A,B} and X drive the board hex/LED displays.

## Interface
- No parameters; operand width fixed at 8 bits.
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- clear_a  in  1  clear X and A to 0
- load_b  in  1  load B from sw
- add_en  in  1  {X,A} <= sext(A) + sext(s_in)
- sub_en  in  1  {X,A} <= sext(A) - sext(s_in)
- shift_en  in  1  arithmetic right shift of X:A:B by one
- sw  in  8  multiplier source for load_b
- s_in  in  8  multiplicand (signed); held stable by upstream for the whole multiply
- b_lsb  out  1  B[0], fed back to control
- x_out  out  1  X register
- a_out  out  8  A register (product high byte)
- b_out  out  8  B register (product low byte)

## Operation
- All state (X, A, B) is updated only on posedge clk. Outputs are direct register copies, with no combinational path from inputs.
- Arithmetic is 9-bit two's complement: sext(v) = {v[7], v}.
  - Add: {X,A} <= {A[7],A} + {s_in[7],s_in}, truncated to 9 bits. B is unchanged.
  - Sub: {X,A} <= {A[7],A} + ~{s_in[7],s_in} + 1, truncated to 9 bits. B is unchanged.
  - The carry out of bit 8 is discarded.
- Shift:
  - X <= X (sign held)
  - A <= {X, A[7:1]}
  - B <= {A[0], B[7:1]}
- Update priority, highest first:
  1. reset: X, A, B <= 0.
  2. clear_a: X, A <= 0. If load_b is also asserted in the same cycle, B <= sw; otherwise B holds. The combined clear_a+load_b is the normal "clear A / load B" command.
  3. load_b alone: B <= sw. X and A hold. Add, sub and shift are ignored in that cycle.
  4. add_en: performs add. It wins over sub_en and shift_en if more than one is asserted.
  5. sub_en: performs sub. It wins over shift_en.
  6. shift_en: performs shift.
  7. No strobe asserted: all registers hold.
- Control issues at most one of add_en/sub_en/shift_en per cycle. The priority above makes any illegal overlap deterministic and is checked by the bench.
- A full multiply is 8 shifts with add/sub interleaved. B[0] is sampled by control before each shift; a sub precedes the 8th shift when B[0]=1. The result is the 16-bit signed product {A,B}.

## Timing
- Reset values: x_out=0, a_out=0x00, b_out=0x00, b_lsb=0.
- Every command has one-cycle latency. A strobe sampled at edge n is visible on the outputs after edge n; b_lsb reflects the new B[0] in the cycle after a load or shift.
- Back-to-back strobes are allowed every cycle, e.g. add then shift on consecutive edges. The shift uses the post-add A and X.
- Reset asserted mid-multiply clears everything at that edge regardless of other strobes. There is no partial update.
- s_in is read combinationally at the add/sub edge. A change on s_in only matters in cycles with add_en or sub_en asserted.

## Test plan
- Reset: reset=1 with add_en=1, s_in=0x7F, sw=0xAA, load_b=1 -> after the edge X=0, A=0x00, B=0x00, b_lsb=0.
- Clear/load plus overflow sign:
  - clear_a=1, load_b=1, sw=0xFD -> X=0, A=0x00, B=0xFD, b_lsb=1.
  - Then add_en, s_in=0xC5 -> X=1, A=0xC5.
  - Then add_en, s_in=0x80 -> X=1, A=0x45 (0x1C5+0x180 truncated).
- Sub then shift:
  - From A=0x00, X=0, B=0x03: sub_en, s_in=0x07 -> X=1, A=0xF9.
  - Then shift_en -> X=1, A=0xFC, B=0x81, b_lsb=1.
- Full multiply 7 × -3: load B=0xFD, s_in=0x07, driven with the control algorithm (add on B[0]=1, shift ×8, sub before the last shift) -> final A=0xFF, B=0xEB (0xFFEB = -21).
- Priority:
  - add_en+sub_en+shift_en together with A=0x10, s_in=0x01 -> A=0x11, B unchanged.
  - load_b+shift_en -> only B loaded.
  - clear_a alone -> B holds.
- Mid-operation reset: after the 4th shift of the previous multiply, assert reset for one cycle -> all outputs 0 on the next cycle. A subsequent full multiply -128 × -128 -> {A,B}=0x4000.
